// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl: raster (x,y) generator for one frame per start pulse; SCAN_BORDER_FLAG_EN adds in_border
module pixel_scan_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          line_start,
    output logic          line_end,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy
`ifdef SCAN_BORDER_FLAG_EN
    ,
    output logic          in_border
`endif
);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // state and coordinate registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // cascaded column/row counters advance only on an accepted coordinate
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SCAN;
                x_d     = '0;
                y_d     = '0;
            end
            SCAN: if (out_ready) begin
                if (x_q != X_MAX) begin
                    x_d = x_q + 1'b1;
                end else begin
                    x_d = '0;
                    if (y_q != Y_MAX) begin
                        y_d = y_q + 1'b1;
                    end else begin
                        y_d     = '0;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
    end

    assign out_valid   = (state_q == SCAN);
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign line_start  = out_valid && (x_q == '0);
    assign line_end    = out_valid && (x_q == X_MAX);
    assign frame_start = out_valid && (x_q == '0) && (y_q == '0);
    assign frame_done  = (state_q == DONE);
    assign busy        = (state_q != IDLE);

`ifdef SCAN_BORDER_FLAG_EN
    localparam logic [XW-1:0] X_LO = XW'(3);
    localparam logic [XW-1:0] X_HI = XW'(IMG_W - 4);
    localparam logic [YW-1:0] Y_LO = YW'(3);
    localparam logic [YW-1:0] Y_HI = YW'(IMG_H - 4);

    assign in_border = out_valid && ((x_q < X_LO) || (x_q > X_HI) || (y_q < Y_LO) || (y_q > Y_HI));
`endif
endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// tb_pixel_scan_ctrl: random/directed stimulus against an index-based raster model
module tb_pixel_scan_ctrl;
    localparam int W = 8;
`ifdef SCAN_BORDER_FLAG_EN
    localparam int H = 8;
`else
    localparam int H = 4;
`endif
    localparam int N = W * H;

    logic clk = 0;
    logic n_rst = 0;
    logic start = 0;
    logic out_ready = 0;
    logic out_valid, line_start, line_end, frame_start, frame_done, busy;
    logic [$clog2(W)-1:0] pix_x;
    logic [$clog2(H)-1:0] pix_y;
`ifdef SCAN_BORDER_FLAG_EN
    logic in_border;
`endif

    int vectors = 0;
    int miscompares = 0;
    int m_ph = 0;
    int m_idx = 0;
    int done_cnt = 0;

    pixel_scan_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .line_end(line_end), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy)
`ifdef SCAN_BORDER_FLAG_EN
        , .in_border(in_border)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int x, y;
        bit v;
        v = (m_ph == 1);
        x = m_idx % W;
        y = m_idx / W;
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("frame_done", 32'(frame_done), 32'(m_ph == 2));
        if (v) begin
            chk("pix_x", 32'(pix_x), 32'(x));
            chk("pix_y", 32'(pix_y), 32'(y));
        end
        chk("line_start", 32'(line_start), 32'(v && x == 0));
        chk("line_end", 32'(line_end), 32'(v && x == W - 1));
        chk("frame_start", 32'(frame_start), 32'(v && m_idx == 0));
`ifdef SCAN_BORDER_FLAG_EN
        chk("in_border", 32'(in_border), 32'(v && (x < 3 || x > W - 4 || y < 3 || y > H - 4)));
`endif
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_x", 32'(pix_x), 0);
        chk("rst_y", 32'(pix_y), 0);
        chk("rst_ls", 32'(line_start), 0);
        chk("rst_le", 32'(line_end), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef SCAN_BORDER_FLAG_EN
        chk("rst_border", 32'(in_border), 0);
`endif
    endtask

    task automatic tick(input logic st, input logic rdy);
        start = st;
        out_ready = rdy;
        case (m_ph)
            0: if (st) begin m_ph = 1; m_idx = 0; end
            1: if (rdy) begin
                if (m_idx == N - 1) begin m_ph = 2; m_idx = 0; end
                else m_idx++;
            end
            default: m_ph = 0;
        endcase
        @(posedge clk);
        #1;
        if (m_ph == 2) done_cnt++;
        check_all();
    endtask

    initial begin
        logic [3:0] pat;
        int g;
        pat = 4'b1001;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        n_rst = 1;
        tick(0, 1);
        tick(0, 0);
        // full-speed frame
        done_cnt = 0;
        tick(1, 1);
        g = 0;
        while (m_ph != 0 && g < 200) begin tick(0, 1); g++; end
        chk("frame1_done_count", 32'(done_cnt), 1);
        tick(0, 1);
        // back-pressure pattern 1,0,0,1
        done_cnt = 0;
        tick(1, 0);
        g = 0;
        while (m_ph != 0 && g < 1000) begin tick(0, pat[g % 4]); g++; end
        chk("frame2_done_count", 32'(done_cnt), 1);
        // start mid-scan at (3,2) ignored
        done_cnt = 0;
        tick(1, 1);
        g = 0;
        while (m_ph == 1 && m_idx != 2 * W + 3 && g < 200) begin tick(0, 1); g++; end
        tick(1, 1);
        g = 0;
        while (m_ph != 0 && g < 200) begin tick(0, 1); g++; end
        chk("frame3_done_count", 32'(done_cnt), 1);
        // async reset at (5,1)
        done_cnt = 0;
        tick(1, 1);
        g = 0;
        while (m_ph == 1 && m_idx != W + 5 && g < 200) begin tick(0, $urandom_range(0, 1) == 1); g++; end
        chk("pre_reset_x", 32'(pix_x), 5);
        #1;
        n_rst = 0;
        #1;
        m_ph = 0;
        m_idx = 0;
        check_reset_vals();
        @(posedge clk);
        #1;
        check_reset_vals();
        n_rst = 1;
        tick(0, 1);
        tick(0, 1);
        chk("reset_done_count", 32'(done_cnt), 0);
        // random start/ready traffic
        for (int i = 0; i < 800; i++) tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        g = 0;
        while (m_ph != 0 && g < 300) begin tick(0, 1); g++; end
        tick(1, 1);
        tick(0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pixel_scan_ctrl.md
Name: pixel_scan_ctrl

Overview:
- Raster-scan coordinate generator for the FAST front end; emits (x, y) for every pixel of one frame, row-major, with a valid/ready handshake.
- Built from two cascaded counters (column, row) with rollover; its outputs drive line-buffer write addressing and the FAST 7x7 window stage downstream.
- One frame per start pulse; reports frame done.

Parameters:
- IMG_W, 64, pixels per row (>=2)
- IMG_H, 48, rows per frame (>=2)
- XW, $clog2(IMG_W), width of pix_x
- YW, $clog2(IMG_H), width of pix_y

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to scan one frame; ignored unless IDLE
- out_ready  in  1  downstream accepts current coordinate
- out_valid  out  1  pix_x/pix_y valid
- pix_x  out  XW  column, 0..IMG_W-1
- pix_y  out  YW  row, 0..IMG_H-1
- line_start  out  1  high with valid when pix_x==0
- line_end  out  1  high with valid when pix_x==IMG_W-1
- frame_start  out  1  high with valid at (0,0)
- frame_done  out  1  one-cycle pulse after last pixel accepted
- busy  out  1  high in SCAN and DONE
- in_border  out  1  only when SCAN_BORDER_FLAG_EN defined (see below)

Behaviour:
- Reset (async, n_rst=0): state IDLE; pix_x=0, pix_y=0; out_valid, line_start, line_end, frame_start, frame_done, busy, in_border all 0.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 -> SCAN next cycle; x=y=0; out_valid=1 from the first SCAN cycle (latency 1 from start).
- SCAN: out_valid=1 continuously. Transfer = out_valid & out_ready. On transfer:
  - x<IMG_W-1: x+1.
  - x==IMG_W-1 and y<IMG_H-1: x=0, y+1.
  - x==IMG_W-1 and y==IMG_H-1: -> DONE; out_valid=0 next cycle.
- Without a transfer, pix_x/pix_y and all flags hold (no skipped or duplicated coordinate under back-pressure).
- Flags are combinational from state and the x/y registers, qualified by out_valid.
- DONE: lasts exactly one cycle; frame_done=1, busy=1; then IDLE with x=y=0. frame_done is not gated by out_ready.
- start in SCAN or DONE is ignored (not queued).
- Exactly IMG_W*IMG_H transfers per frame.
- n_rst asserted mid-frame: immediate return to IDLE with reset values; no frame_done.
- Counter arithmetic is unsigned; x and y never exceed IMG_W-1 / IMG_H-1, including non-power-of-2 sizes.

Optional Feature:
- Macro SCAN_BORDER_FLAG_EN.
- Defined: port in_border exists. It is 1 with out_valid when x<3, x>IMG_W-4, y<3 or y>IMG_H-4 (FAST radius-3 ring does not fit), else 0; 0 when out_valid=0. Requires IMG_W, IMG_H >= 7.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- IMG_W=8, IMG_H=4; reset then start pulse, out_ready=1 -> out_valid rises next cycle at (0,0) with frame_start=1; 32 consecutive transfers; frame_done pulses one cycle after (7,3) is accepted; busy drops the cycle after.
- Same sizes; out_ready toggling 1,0,0,1 pattern -> captured coordinate sequence is exactly 0..31 in raster order, no repeats or gaps; flags stable while stalled.
- Row wrap: at (7,0) with line_end=1, transfer -> (0,1) with line_start=1; at (7,3) transfer -> out_valid=0, frame_done=1.
- start asserted at (3,2) mid-scan -> no effect; frame completes after 32 transfers with exactly one frame_done; a second start afterwards rescans from (0,0).
- n_rst pulsed low asynchronously at (5,1) -> outputs go to reset values immediately; no frame_done; next start begins at (0,0).
- SCAN_BORDER_FLAG_EN defined, IMG_W=IMG_H=8 -> in_border=0 only for x,y in {3,4} (4 pixels); 60 of 64 transfers flagged.
